// File: rtl/root_arbiter.sv
// root_arbiter: round-robin front end that shares one root engine between
// NREQ requesters, holding the engine inputs steady during the computation,
// bounding the wait with a timeout and resetting the engine when it expires.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           per-requester request / one-hot accept
//   req_radicand, req_degree      packed per-requester operands (10 / 3 bits each)
//   rsp_valid/rsp_ready           result handshake towards the consumer
//   rsp_id, rsp_data, rsp_err     owning requester, Q10.10 root, error flag
//   eng_in_valid, eng_in_data_1/2 launch strobe and held operands to the engine
//   eng_out_valid, eng_out_data   engine result strobe and value
//   eng_rst_n                     engine reset, active-low
module root_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*10-1:0] req_radicand,
   input  logic [NREQ*3-1:0] req_degree,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [2:0]        rsp_id,
   output logic [19:0]       rsp_data,
   output logic              rsp_err,
   output logic              eng_in_valid,
   output logic [9:0]        eng_in_data_1,
   output logic [2:0]        eng_in_data_2,
   input  logic              eng_out_valid,
   input  logic [19:0]       eng_out_data,
   output logic              eng_rst_n
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned IW = 3;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_HOLD,
      S_RESP,
      S_ERESET
   } state_t;

   state_t          state;
   logic [PW-1:0]   last_grant;
   logic [CW-1:0]   counter;

   logic [9:0]      rad_a [NREQ];
   logic [2:0]      deg_a [NREQ];
   logic [PW-1:0]   scan_idx;
   logic [PW-1:0]   grant_idx;
   logic            any_req;
   logic            grant;

   // Unpack the flat operand buses into per-requester arrays.
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign rad_a[i] = req_radicand[10*i +: 10];
      assign deg_a[i] = req_degree[3*i +: 3];
   end

   // Round-robin scan: first requesting index after last_grant, wrapping.
   always_comb begin
      any_req   = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         scan_idx = PW'((32'(last_grant) + k) % NREQ);
         if (!any_req && req_valid[scan_idx]) begin
            any_req   = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   // A grant is only possible in IDLE once any engine result tail has drained.
   assign grant = (state == S_IDLE) && !rst && !eng_out_valid && any_req;

   // The accept must answer the requester in the same cycle it is offered.
   always_comb begin
      req_ready = '0;
      if (grant) req_ready[grant_idx] = 1'b1;
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         last_grant    <= PW'(NREQ - 1);
         counter       <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
         eng_in_valid  <= 1'b0;
         eng_in_data_1 <= '0;
         eng_in_data_2 <= '0;
         eng_rst_n     <= 1'b0;
      end else begin
         eng_in_valid <= 1'b0;
         eng_rst_n    <= 1'b1;
         case (state)
            S_IDLE: begin
               if (grant) begin
                  last_grant    <= grant_idx;
                  rsp_id        <= IW'(grant_idx);
                  eng_in_data_1 <= rad_a[grant_idx];
                  eng_in_data_2 <= deg_a[grant_idx];
                  if (deg_a[grant_idx] == 3'd0) begin
                     // Degree 0 has no root: answer with an error, skip the engine.
                     rsp_data  <= '0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     eng_in_valid <= 1'b1;
                     counter      <= '0;
                     state        <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               counter <= '0;
               state   <= S_HOLD;
            end
            S_HOLD: begin
               if (eng_out_valid) begin
                  rsp_data  <= eng_out_data;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else if (counter == CW'(TIMEOUT - 1)) begin
                  // Last permitted HOLD cycle without a result: reset the engine.
                  counter   <= '0;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  eng_rst_n <= 1'b0;
                  state     <= S_ERESET;
               end else begin
                  counter <= counter + CW'(1);
               end
            end
            S_ERESET: begin
               // Two cycles of engine reset, counted with the shared counter.
               if (counter == CW'(1)) begin
                  counter   <= '0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  counter   <= counter + CW'(1);
                  eng_rst_n <= 1'b0;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
